mmio_tx_port: RTL and testbench

MMIO_TX_PORT -- requirements
Module: mmio_tx_port

---
 rtl/mmio_tx_port.sv | 177 +++++++++++++++++
 tb/tb_mmio_tx_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx_port.sv
// mmio_tx_port: memory-mapped serial transmitter with a 4-entry byte FIFO.
//
// Register window (word addresses):
//   BASE_ADDR     DATA   write pushes wdata[7:0]; reads as 0
//   BASE_ADDR+4   STATUS {25'b0, ovf, count[2:0], busy, empty, full};
//                        write with wdata[6]=1 clears ovf
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-low
//   addr   in   CPU byte address
//   wr     in   CPU write strobe
//   wdata  in   CPU store data
//   hit    out  address falls in this block's window (combinational)
//   rdata  out  read data, 0 when hit=0 (combinational)
//   tx     out  serial line, idle high; frame = start, 8 data LSB first, stop
//   irq    out  FIFO drained and transmitter idle, after at least one frame
module mmio_tx_port #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_00F8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] mem_q [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [1:0] state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sent_q, sent_d;
  logic       irq_q, irq_d;

  logic sel_data, sel_stat;
  logic push_req, push, pop, bit_end;
  logic busy, empty, full;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign sel_data = (addr == BASE_ADDR);
  assign sel_stat = (addr == BASE_ADDR + 32'd4);
  assign hit      = sel_data | sel_stat;

  assign busy  = (state_q != S_IDLE);
  assign empty = (cnt_q == 3'd0);
  assign full  = (cnt_q == 3'd4);

  assign rdata = sel_stat ? {25'b0, ovf_q, cnt_q, busy, empty, full} : 32'h0;

  // Decoded straight from state so an async reset returns the line high at once.
  assign tx  = (state_q == S_START) ? 1'b0 :
               (state_q == S_DATA)  ? shreg_q[0] : 1'b1;
  assign irq = irq_q;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sent_d  = sent_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = 8'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = 8'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 8'd0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: begin // S_STOP
        if (bit_end) begin
          baud_d = 8'd0;
          sent_d = 1'b1;
          // Chain straight into the next frame when bytes are waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
    endcase

    if (pop) begin
      shreg_d = mem_q[rp_q];
      rp_d    = rp_q + 2'd1;
    end

    // A pop in the same edge frees a slot, so a push into a full FIFO lands.
    push_req = wr && sel_data;
    push     = push_req && (!full || pop);
    if (push) wp_d = wp_q + 2'd1;
    if (push_req && !push) ovf_d = 1'b1;
    if (wr && sel_stat && wdata[6]) ovf_d = 1'b0;

    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
    irq_d = sent_d && (state_d == S_IDLE) && (cnt_d == 3'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= 2'd0;
      rp_q    <= 2'd0;
      cnt_q   <= 3'd0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      sent_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sent_q  <= sent_d;
      irq_q   <= irq_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_tx_port.sv
module tb_mmio_tx_port;
  localparam logic [31:0] BASE = 32'h0000_00F8;
  localparam int          CPB  = 4;
  localparam int          FLEN = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  mmio_tx_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata),
    .hit(hit), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; the write lands on the next edge.
  task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd_stat(output logic [31:0] v);
    addr = BASE + 32'd4;
    #1 v = rdata;
    addr = 32'h0;
  endtask

  // Waits for a start bit, then captures the whole frame cycle by cycle and
  // compares it with the waveform expected for the scoreboard's head byte.
  task automatic rx_frame(input string tag);
    bit seen = 0;
    logic [7:0] b;
    logic [FLEN-1:0] got_w, exp_w;
    for (int w = 0; w < 400 && !seen; w++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    if (!seen) begin
      chk({tag, "_start"}, tx, 0);
      return;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_sb"}, exp_q.size(), 1);
      return;
    end
    b = exp_q.pop_front();
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) @(negedge clk);
      got_w[k] = tx;
      if (k / CPB == 0)      exp_w[k] = 1'b0;
      else if (k / CPB == 9) exp_w[k] = 1'b1;
      else                   exp_w[k] = b[k / CPB - 1];
    end
    chk(tag, 64'(got_w), 64'(exp_w));
  endtask

  task automatic tx_quiet(input string tag, input int cycles);
    logic lo = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lo = 1'b0;
    end
    chk(tag, lo, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    reset = 1'b0; addr = 32'h0; wr = 1'b0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
    @(negedge clk) reset = 1'b1;

    // Reset state
    #1 rd_stat(st);
    chk("rst_status", st, 32'h0000_0002);
    addr = BASE + 32'd4;
    #1 chk("hit_stat", hit, 1);
    addr = BASE;
    #1 chk("hit_data", hit, 1);
    chk("rd_data", rdata, 32'h0);
    addr = 32'h0;

    // Single frame, pushed on the first edge after reset
    exp_q.push_back(8'h55);
    wr_cyc(BASE, 32'hABCD_0055);
    rx_frame("frame_55");
    @(negedge clk);
    chk("irq_after_55", irq, 1);

    // Back-to-back pushes: one pops at once, four queue, the sixth drops
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i < 5) exp_q.push_back(8'(8'hA1 + i));
          wr_cyc(BASE, 32'(8'hA1 + i));
        end
        rd_stat(st);
        chk("status_full_ovf", st, 32'h0000_0065);
      end
      begin
        for (int f = 0; f < 5; f++) rx_frame($sformatf("burst_%0d", f));
      end
    join
    @(negedge clk);
    chk("irq_after_burst", irq, 1);
    chk("sb_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    rd_stat(st);
    chk("status_ovf_idle", st, 32'h0000_0042);

    // ovf clear semantics
    wr_cyc(BASE + 32'd4, 32'h0);
    rd_stat(st);
    chk("ovf_keep_0", st, 32'h0000_0042);
    wr_cyc(BASE + 32'd4, 32'hFFFF_FFBF);
    rd_stat(st);
    chk("ovf_keep_bf", st, 32'h0000_0042);
    wr_cyc(BASE + 32'd4, 32'h40);
    rd_stat(st);
    chk("ovf_clear", st, 32'h0000_0002);

    // Out-of-window writes
    addr = BASE + 32'd8;
    #1 chk("miss_hi_hit", hit, 0);
    chk("miss_hi_rdata", rdata, 32'h0);
    addr = BASE - 32'd4;
    #1 chk("miss_lo_hit", hit, 0);
    chk("miss_lo_rdata", rdata, 32'h0);
    wr_cyc(BASE + 32'd8, 32'h77);
    wr_cyc(BASE - 32'd4, 32'h77);
    rd_stat(st);
    chk("miss_status", st, 32'h0000_0002);
    tx_quiet("miss_no_frame", 60);
    chk("miss_irq", irq, 1);

    // Reset during data bit 3 of 0xF0 (bit 3 = 0), with a second byte queued
    @(posedge clk); #1;
    exp_q.push_back(8'hF0);
    wr_cyc(BASE, 32'hF0);
    exp_q.push_back(8'h3C);
    wr_cyc(BASE, 32'h3C);
    begin
      bit seen = 0;
      for (int w = 0; w < 50 && !seen; w++) begin
        @(negedge clk);
        if (tx === 1'b0) seen = 1;
      end
      chk("abort_start", seen, 1);
    end
    repeat (4 * CPB + 1) @(negedge clk);
    chk("abort_bit3", tx, 0);
    reset = 1'b0;
    exp_q.delete();
    #1 chk("abort_tx_async", tx, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 rd_stat(st);
    chk("abort_status", st, 32'h0000_0002);
    chk("abort_irq", irq, 0);
    tx_quiet("abort_no_frame", 100);
    chk("abort_irq_late", irq, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
